dp_onchip_ram_pipe: RTL and testbench

//  Parametrised dual-port Avalon-MM on-chip RAM. Next generation of the board-level
//  TLB-miss/exception-handler RAM: configurable width/depth and read latency,

---
 rtl/dp_ram_pkg.sv | 24 ++
 rtl/dp_ram_rd_pipe.sv | 93 +++++++++
 rtl/dp_onchip_ram_pipe.sv | 154 +++++++++++++++
 tb/tb_dp_onchip_ram_pipe.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_ram_pkg.sv
// Shared constants and helpers for the dual-port on-chip RAM.
//   BYTE_W          : bits per byte lane
//   LAT_MIN/LAT_MAX : legal READ_LATENCY range
//   lane_cnt_t      : type used for byte-lane counts
//   lane_count()    : byte lanes for a given data width
//   even_par()      : even-parity bit of one byte lane
package dp_ram_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned LAT_MIN = 1;
    localparam int unsigned LAT_MAX = 2;

    typedef int unsigned lane_cnt_t;

    function automatic lane_cnt_t lane_count(input int unsigned data_w);
        return lane_cnt_t'(data_w / BYTE_W);
    endfunction

    // Parity bit that makes the 9-bit group {par, byte} have an even number of ones.
    function automatic logic even_par(input logic [BYTE_W-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/dp_ram_rd_pipe.sv
// Read-return pipeline for one RAM port.
// Ports:
//   clk, reset     : clock, synchronous active-high reset (discards in-flight reads)
//   accept         : a read is accepted this cycle; rd_word is the array word at that address
//   rd_word        : array word read at accept time (pre-write, so mixed-port reads see old data)
//   rd_par         : stored lane parity for rd_word (DP_RAM_PARITY_EN only)
//   par_bad_c      : parity mismatch on the word being returned at the next edge (DP_RAM_PARITY_EN only)
//   readdata       : returned data, holds its value while readdatavalid is low
//   readdatavalid  : one-cycle pulse READ_LATENCY cycles after accept
module dp_ram_rd_pipe
    import dp_ram_pkg::*;
#(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              accept,
    input  logic [DATA_W-1:0] rd_word,
`ifdef DP_RAM_PARITY_EN
    input  logic [DATA_W/BYTE_W-1:0] rd_par,
    output logic              par_bad_c,
`endif
    output logic [DATA_W-1:0] readdata,
    output logic              readdatavalid
);

    // Input to the output register: the accepted word directly (latency 1) or one stage later.
    logic              st_v;
    logic [DATA_W-1:0] st_d;

`ifdef DP_RAM_PARITY_EN
    logic rd_bad;
    logic st_bad;

    // Recompute each lane's parity and compare with the stored bits.
    always_comb begin
        rd_bad = 1'b0;
        for (int unsigned b = 0; b < DATA_W / BYTE_W; b++) begin
            rd_bad = rd_bad | (even_par(rd_word[b*BYTE_W +: BYTE_W]) != rd_par[b]);
        end
    end
`endif

    generate
        if (READ_LATENCY >= 2) begin : g_stage
            // Extra stage for the two-cycle configuration.
            always_ff @(posedge clk) begin
                if (reset) begin
                    st_v <= 1'b0;
                    st_d <= '0;
`ifdef DP_RAM_PARITY_EN
                    st_bad <= 1'b0;
`endif
                end else begin
                    st_v <= accept;
                    if (accept) begin
                        st_d <= rd_word;
`ifdef DP_RAM_PARITY_EN
                        st_bad <= rd_bad;
`endif
                    end
                end
            end
        end else begin : g_direct
            always_comb begin
                st_v = accept;
                st_d = rd_word;
`ifdef DP_RAM_PARITY_EN
                st_bad = rd_bad;
`endif
            end
        end
    endgenerate

    // Output register only loads on a returning read so readdata holds otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata      <= '0;
            readdatavalid <= 1'b0;
        end else begin
            readdatavalid <= st_v;
            if (st_v) begin
                readdata <= st_d;
            end
        end
    end

`ifdef DP_RAM_PARITY_EN
    assign par_bad_c = st_v & st_bad;
`endif

endmodule

// File: rtl/dp_onchip_ram_pipe.sv
// Dual-port Avalon-MM on-chip RAM with pipelined reads and defined collision behaviour.
// s1 serves the instruction master, s2 the data master, both on clk.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset (RAM contents kept)
//   sN_address/byteenable      : word address and byte lanes
//   sN_chipselect/read/write   : request qualifiers; read+write together is a write
//   sN_writedata/readdata      : write and returned read data
//   sN_readdatavalid           : one-cycle pulse READ_LATENCY cycles after an accepted read
//   s2_waitrequest             : combinational stall of s2 on a same-address write collision
//   parity_err                 : sticky parity error (only when DP_RAM_PARITY_EN is defined)
// Build option: DP_RAM_PARITY_EN adds per-lane even parity storage and checking.
module dp_onchip_ram_pipe
    import dp_ram_pkg::*;
#(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned READ_LATENCY = 1,
    parameter string       INIT_FILE    = ""
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        s1_address,
    input  logic [DATA_W/BYTE_W-1:0] s1_byteenable,
    input  logic                     s1_chipselect,
    input  logic                     s1_read,
    input  logic                     s1_write,
    input  logic [DATA_W-1:0]        s1_writedata,
    output logic [DATA_W-1:0]        s1_readdata,
    output logic                     s1_readdatavalid,
    input  logic [ADDR_W-1:0]        s2_address,
    input  logic [DATA_W/BYTE_W-1:0] s2_byteenable,
    input  logic                     s2_chipselect,
    input  logic                     s2_read,
    input  logic                     s2_write,
    input  logic [DATA_W-1:0]        s2_writedata,
    output logic [DATA_W-1:0]        s2_readdata,
    output logic                     s2_readdatavalid,
`ifdef DP_RAM_PARITY_EN
    output logic                     parity_err,
`endif
    output logic                     s2_waitrequest
);

    localparam lane_cnt_t   LANES = lane_count(DATA_W);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    // Elaboration-time parameter checks.
    generate
        if (READ_LATENCY < LAT_MIN || READ_LATENCY > LAT_MAX) begin : g_bad_latency
            $error("dp_onchip_ram_pipe: READ_LATENCY must be 1 or 2");
        end
        if (DATA_W % BYTE_W != 0 || DATA_W == 0) begin : g_bad_width
            $error("dp_onchip_ram_pipe: DATA_W must be a non-zero multiple of 8");
        end
        if (INIT_FILE != "") begin : g_init_file
            // Preload is applied by the implementation flow's memory-init mechanism.
        end
    endgenerate

    logic [DATA_W-1:0] mem [DEPTH];
`ifdef DP_RAM_PARITY_EN
    logic [LANES-1:0]  mem_par [DEPTH];
`endif

    logic s1_wr;
    logic s1_rd;
    logic s2_wr_req;
    logic s2_wr;
    logic s2_rd;
    logic collide;

    // s1 has priority on a same-address write; byteenable overlap is ignored.
    assign s1_wr     = s1_chipselect & s1_write;
    assign s1_rd     = s1_chipselect & s1_read & ~s1_write;
    assign s2_wr_req = s2_chipselect & s2_write;
    assign collide   = s1_wr & s2_wr_req & (s1_address == s2_address);

    assign s2_waitrequest = collide & ~reset;
    assign s2_wr          = s2_wr_req & ~s2_waitrequest;
    assign s2_rd          = s2_chipselect & s2_read & ~s2_write & ~s2_waitrequest;

    // Byte-lane writes; s1 is applied last so it wins if both land on one address.
    always_ff @(posedge clk) begin
        for (int unsigned b = 0; b < LANES; b++) begin
            if (s2_wr && s2_byteenable[b]) begin
                mem[s2_address][b*BYTE_W +: BYTE_W] <= s2_writedata[b*BYTE_W +: BYTE_W];
`ifdef DP_RAM_PARITY_EN
                mem_par[s2_address][b] <= even_par(s2_writedata[b*BYTE_W +: BYTE_W]);
`endif
            end
            if (s1_wr && s1_byteenable[b]) begin
                mem[s1_address][b*BYTE_W +: BYTE_W] <= s1_writedata[b*BYTE_W +: BYTE_W];
`ifdef DP_RAM_PARITY_EN
                mem_par[s1_address][b] <= even_par(s1_writedata[b*BYTE_W +: BYTE_W]);
`endif
            end
        end
    end

    // Array is sampled before this edge's writes land, giving old data on mixed-port access.
    logic [DATA_W-1:0] s1_word;
    logic [DATA_W-1:0] s2_word;
    assign s1_word = mem[s1_address];
    assign s2_word = mem[s2_address];

`ifdef DP_RAM_PARITY_EN
    logic s1_par_bad_c;
    logic s2_par_bad_c;
`endif

    dp_ram_rd_pipe #(
        .DATA_W       (DATA_W),
        .READ_LATENCY (READ_LATENCY)
    ) u_rd_s1 (
        .clk           (clk),
        .reset         (reset),
        .accept        (s1_rd),
        .rd_word       (s1_word),
`ifdef DP_RAM_PARITY_EN
        .rd_par        (mem_par[s1_address]),
        .par_bad_c     (s1_par_bad_c),
`endif
        .readdata      (s1_readdata),
        .readdatavalid (s1_readdatavalid)
    );

    dp_ram_rd_pipe #(
        .DATA_W       (DATA_W),
        .READ_LATENCY (READ_LATENCY)
    ) u_rd_s2 (
        .clk           (clk),
        .reset         (reset),
        .accept        (s2_rd),
        .rd_word       (s2_word),
`ifdef DP_RAM_PARITY_EN
        .rd_par        (mem_par[s2_address]),
        .par_bad_c     (s2_par_bad_c),
`endif
        .readdata      (s2_readdata),
        .readdatavalid (s2_readdatavalid)
    );

`ifdef DP_RAM_PARITY_EN
    // Sticky error, set on the same edge that raises readdatavalid for the bad word.
    always_ff @(posedge clk) begin
        if (reset) begin
            parity_err <= 1'b0;
        end else if (s1_par_bad_c || s2_par_bad_c) begin
            parity_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_dp_onchip_ram_pipe.sv
// Self-checking bench for dp_onchip_ram_pipe: two instances (READ_LATENCY 1 and 2) share
// all inputs; a word-level memory model plus per-port expectation queues predict outputs.
module tb_dp_onchip_ram_pipe;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b1;
    logic [AW-1:0] s1_address = '0, s2_address = '0;
    logic [3:0]    s1_byteenable = '0, s2_byteenable = '0;
    logic          s1_chipselect = 1'b0, s2_chipselect = 1'b0;
    logic          s1_read = 1'b0, s2_read = 1'b0;
    logic          s1_write = 1'b0, s2_write = 1'b0;
    logic [DW-1:0] s1_writedata = '0, s2_writedata = '0;

    logic [DW-1:0] rdata  [2][2];
    logic          rvalid [2][2];
    logic          wreq   [2];
`ifdef DP_RAM_PARITY_EN
    logic          perr   [2];
`endif

    dp_onchip_ram_pipe #(.DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(1), .INIT_FILE("")) dut (
        .clk(clk), .reset(reset),
        .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_chipselect(s1_chipselect),
        .s1_read(s1_read), .s1_write(s1_write), .s1_writedata(s1_writedata),
        .s1_readdata(rdata[0][0]), .s1_readdatavalid(rvalid[0][0]),
        .s2_address(s2_address), .s2_byteenable(s2_byteenable), .s2_chipselect(s2_chipselect),
        .s2_read(s2_read), .s2_write(s2_write), .s2_writedata(s2_writedata),
        .s2_readdata(rdata[0][1]), .s2_readdatavalid(rvalid[0][1]),
`ifdef DP_RAM_PARITY_EN
        .parity_err(perr[0]),
`endif
        .s2_waitrequest(wreq[0])
    );

    dp_onchip_ram_pipe #(.DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(2), .INIT_FILE("")) dut2 (
        .clk(clk), .reset(reset),
        .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_chipselect(s1_chipselect),
        .s1_read(s1_read), .s1_write(s1_write), .s1_writedata(s1_writedata),
        .s1_readdata(rdata[1][0]), .s1_readdatavalid(rvalid[1][0]),
        .s2_address(s2_address), .s2_byteenable(s2_byteenable), .s2_chipselect(s2_chipselect),
        .s2_read(s2_read), .s2_write(s2_write), .s2_writedata(s2_writedata),
        .s2_readdata(rdata[1][1]), .s2_readdatavalid(rvalid[1][1]),
`ifdef DP_RAM_PARITY_EN
        .parity_err(perr[1]),
`endif
        .s2_waitrequest(wreq[1])
    );

    // ---------------- reference model ----------------
    typedef struct {
        int unsigned   due;
        logic [DW-1:0] data;
    } exp_t;

    logic [DW-1:0] mmem [1 << AW];
    exp_t          pend [4][$];
    logic [DW-1:0] hold_q [4];
    int unsigned   nval [4];
    int unsigned   cyc = 0;
    int            n_chk = 0;
    int            n_bad = 0;

    function automatic int unsigned lat(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mwrite(input logic [AW-1:0] a, input logic [3:0] be, input logic [DW-1:0] d);
        for (int b = 0; b < 4; b++)
            if (be[b]) mmem[a][b*8 +: 8] = d[b*8 +: 8];
    endtask

    // op: 0 idle, 1 read, 2 write, 3 read+write
    task automatic drive(input int port, input logic [1:0] op, input logic [AW-1:0] a,
                         input logic [3:0] be, input logic [DW-1:0] d);
        if (port == 1) begin
            s1_chipselect = (op != 2'd0); s1_read = op[0]; s1_write = op[1];
            s1_address = a; s1_byteenable = be; s1_writedata = d;
        end else begin
            s2_chipselect = (op != 2'd0); s2_read = op[0]; s2_write = op[1];
            s2_address = a; s2_byteenable = be; s2_writedata = d;
        end
    endtask

    // One clock: check waitrequest, predict, clock, then check read returns.
    // With tab=1 the stall and read data expectations come from the caller instead of the model.
    task automatic step(input bit tab, input logic ew, input logic [DW-1:0] e1, input logic [DW-1:0] e2);
        logic coll, w1, r1, w2, r2, rst;
        logic [DW-1:0] d1, d2;
        int idx;
        #2;
        rst  = reset;
        coll = !rst && s1_chipselect && s1_write && s2_chipselect && s2_write
               && (s1_address == s2_address);
        chk("waitrequest_lat1", DW'(wreq[0]), DW'(tab ? ew : coll));
        chk("waitrequest_lat2", DW'(wreq[1]), DW'(tab ? ew : coll));
        w1 = s1_chipselect && s1_write;
        r1 = s1_chipselect && s1_read && !s1_write;
        w2 = s2_chipselect && s2_write && !coll;
        r2 = s2_chipselect && s2_read && !s2_write && !coll;
        d1 = tab ? e1 : mmem[s1_address];
        d2 = tab ? e2 : mmem[s2_address];
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                if (r1) pend[d*2].push_back('{cyc + lat(d), d1});
                if (r2) pend[d*2+1].push_back('{cyc + lat(d), d2});
            end
        end
        if (w2) mwrite(s2_address, s2_byteenable, s2_writedata);
        if (w1) mwrite(s1_address, s1_byteenable, s1_writedata);
        @(posedge clk);
        cyc++;
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                pend[i].delete();
                hold_q[i] = '0;
            end
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                logic ev;
                idx = d*2 + p;
                while (pend[idx].size() > 0 && pend[idx][0].due < cyc) void'(pend[idx].pop_front());
                ev = (pend[idx].size() > 0) && (pend[idx][0].due == cyc);
                chk($sformatf("readdatavalid_lat%0d_s%0d", d+1, p+1), DW'(rvalid[d][p]), DW'(ev));
                if (rvalid[d][p]) nval[idx]++;
                if (ev) hold_q[idx] = pend[idx].pop_front().data;
                chk($sformatf("readdata_lat%0d_s%0d", d+1, p+1), rdata[d][p], hold_q[idx]);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1, 2'd0, '0, '0, '0);
            drive(2, 2'd0, '0, '0, '0);
            step(1'b0, 1'b0, '0, '0);
        end
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [1:0]    op1; logic [AW-1:0] a1; logic [3:0] be1; logic [DW-1:0] d1;
        logic [1:0]    op2; logic [AW-1:0] a2; logic [3:0] be2; logic [DW-1:0] d2;
        logic          ew;  logic [DW-1:0] e1; logic [DW-1:0] e2;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] op1, input logic [AW-1:0] a1, input logic [3:0] be1,
                                input logic [DW-1:0] d1, input logic [1:0] op2, input logic [AW-1:0] a2,
                                input logic [3:0] be2, input logic [DW-1:0] d2, input logic ew,
                                input logic [DW-1:0] e1, input logic [DW-1:0] e2);
        vec_t v;
        v.op1 = op1; v.a1 = a1; v.be1 = be1; v.d1 = d1;
        v.op2 = op2; v.a2 = a2; v.be2 = be2; v.d2 = d2;
        v.ew = ew; v.e1 = e1; v.e2 = e2;
        return v;
    endfunction

    vec_t tab [$];

    initial begin
        int unsigned b0 [4];
        logic hold2;
        logic [1:0] op;

        tab.push_back(mk(2'd2, 8'h10, 4'hF, 32'hDEADBEEF, 2'd0, 8'h00, 4'h0, 32'h0,        1'b0, 32'h0,        32'h0));
        tab.push_back(mk(2'd1, 8'h10, 4'hF, 32'h0,        2'd0, 8'h00, 4'h0, 32'h0,        1'b0, 32'hDEADBEEF, 32'h0));
        tab.push_back(mk(2'd0, 8'h00, 4'h0, 32'h0,        2'd2, 8'h20, 4'hF, 32'hFFFFFFFF, 1'b0, 32'h0,        32'h0));
        tab.push_back(mk(2'd0, 8'h00, 4'h0, 32'h0,        2'd2, 8'h20, 4'h5, 32'h11223344, 1'b0, 32'h0,        32'h0));
        tab.push_back(mk(2'd0, 8'h00, 4'h0, 32'h0,        2'd1, 8'h20, 4'hF, 32'h0,        1'b0, 32'h0,        32'hFF22FF44));
        tab.push_back(mk(2'd2, 8'h30, 4'hF, 32'hAAAA0000, 2'd2, 8'h30, 4'hF, 32'h0000BBBB, 1'b1, 32'h0,        32'h0));
        tab.push_back(mk(2'd0, 8'h00, 4'h0, 32'h0,        2'd2, 8'h30, 4'hF, 32'h0000BBBB, 1'b0, 32'h0,        32'h0));
        tab.push_back(mk(2'd1, 8'h30, 4'hF, 32'h0,        2'd1, 8'h30, 4'hF, 32'h0,        1'b0, 32'h0000BBBB, 32'h0000BBBB));
        tab.push_back(mk(2'd2, 8'h40, 4'hF, 32'h1,        2'd0, 8'h00, 4'h0, 32'h0,        1'b0, 32'h0,        32'h0));
        tab.push_back(mk(2'd1, 8'h40, 4'hF, 32'h0,        2'd2, 8'h40, 4'hF, 32'h2,        1'b0, 32'h1,        32'h0));
        tab.push_back(mk(2'd1, 8'h40, 4'hF, 32'h0,        2'd0, 8'h00, 4'h0, 32'h0,        1'b0, 32'h2,        32'h0));
        tab.push_back(mk(2'd1, 8'h20, 4'hF, 32'h0,        2'd1, 8'h10, 4'hF, 32'h0,        1'b0, 32'hFF22FF44, 32'hDEADBEEF));
        tab.push_back(mk(2'd2, 8'hFF, 4'hF, 32'h12345678, 2'd2, 8'h00, 4'hF, 32'h0,        1'b0, 32'h0,        32'h0));
        tab.push_back(mk(2'd0, 8'h00, 4'h0, 32'h0,        2'd2, 8'h00, 4'h8, 32'hA5A5A5A5, 1'b0, 32'h0,        32'h0));
        tab.push_back(mk(2'd1, 8'h00, 4'hF, 32'h0,        2'd1, 8'hFF, 4'hF, 32'h0,        1'b0, 32'hA5000000, 32'h12345678));
        tab.push_back(mk(2'd3, 8'h60, 4'hF, 32'h600DF00D, 2'd0, 8'h00, 4'h0, 32'h0,        1'b0, 32'h0,        32'h0));
        tab.push_back(mk(2'd1, 8'h60, 4'hF, 32'h0,        2'd0, 8'h00, 4'h0, 32'h0,        1'b0, 32'h600DF00D, 32'h0));

        for (int i = 0; i < 4; i++) begin hold_q[i] = '0; nval[i] = 0; end

        // Reset: outputs cleared, no stall.
        reset = 1'b1;
        idle(2);
        reset = 1'b0;

        // Give every word a known value so model and RAM agree.
        for (int a = 0; a < (1 << AW); a++) begin
            drive(1, 2'd2, AW'(a), 4'hF, $urandom);
            drive(2, 2'd0, '0, '0, '0);
            step(1'b0, 1'b0, '0, '0);
        end
        idle(2);

        // Directed vectors.
        for (int i = 0; i < tab.size(); i++) begin
            drive(1, tab[i].op1, tab[i].a1, tab[i].be1, tab[i].d1);
            drive(2, tab[i].op2, tab[i].a2, tab[i].be2, tab[i].d2);
            step(1'b1, tab[i].ew, tab[i].e1, tab[i].e2);
        end
        idle(3);

`ifdef DP_RAM_PARITY_EN
        // Corrupt one stored bit, read it back: sticky error raised with readdatavalid.
        drive(1, 2'd2, 8'h50, 4'hF, 32'h0F0F0F0F);
        step(1'b0, 1'b0, '0, '0);
        dut.mem[8'h50][3]  = ~dut.mem[8'h50][3];
        dut2.mem[8'h50][3] = ~dut2.mem[8'h50][3];
        mmem[8'h50][3]     = ~mmem[8'h50][3];
        drive(1, 2'd1, 8'h50, 4'hF, '0);
        step(1'b0, 1'b0, '0, '0);
        chk("parity_err_lat1_with_valid", DW'(perr[0]), DW'(1));
        chk("parity_err_lat2_before_valid", DW'(perr[1]), DW'(0));
        idle(1);
        chk("parity_err_lat2_with_valid", DW'(perr[1]), DW'(1));
        idle(3);
        chk("parity_err_lat1_sticky", DW'(perr[0]), DW'(1));
        chk("parity_err_lat2_sticky", DW'(perr[1]), DW'(1));
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        chk("parity_err_lat1_reset", DW'(perr[0]), DW'(0));
        chk("parity_err_lat2_reset", DW'(perr[1]), DW'(0));
        drive(1, 2'd2, 8'h50, 4'hF, 32'h0F0F0F0F);
        step(1'b0, 1'b0, '0, '0);
        idle(1);
`endif

        // Back-to-back reads of 0..7 on both ports: 8 returns per port per instance.
        for (int i = 0; i < 4; i++) b0[i] = nval[i];
        for (int i = 0; i < 8; i++) begin
            drive(1, 2'd1, AW'(i), 4'hF, '0);
            drive(2, 2'd1, AW'(7 - i), 4'hF, '0);
            step(1'b0, 1'b0, '0, '0);
        end
        idle(3);
        for (int i = 0; i < 4; i++)
            chk($sformatf("burst_valid_count_%0d", i), DW'(nval[i] - b0[i]), DW'(8));

        // Reset during a burst: reads at and after the reset edge never return.
        for (int i = 0; i < 4; i++) b0[i] = nval[i];
        for (int i = 0; i < 5; i++) begin
            reset = (i == 4);
            drive(1, 2'd1, AW'(i), 4'hF, '0);
            drive(2, 2'd1, AW'(i + 8), 4'hF, '0);
            step(1'b0, 1'b0, '0, '0);
        end
        reset = 1'b0;
        idle(5);
        chk("reset_burst_count_lat1_s1", DW'(nval[0] - b0[0]), DW'(4));
        chk("reset_burst_count_lat1_s2", DW'(nval[1] - b0[1]), DW'(4));
        chk("reset_burst_count_lat2_s1", DW'(nval[2] - b0[2]), DW'(3));
        chk("reset_burst_count_lat2_s2", DW'(nval[3] - b0[3]), DW'(3));

        // Random traffic over a small address window to provoke collisions; s2 holds when stalled.
        hold2 = 1'b0;
        for (int k = 0; k < 800; k++) begin
            reset = ($urandom_range(0, 99) == 0);
            op = ($urandom_range(0, 5) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
            drive(1, op, ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7)),
                  4'($urandom), $urandom);
            if (!hold2) begin
                op = ($urandom_range(0, 5) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
                drive(2, op, AW'($urandom_range(0, 7)), 4'($urandom), $urandom);
            end
            hold2 = !reset && s1_chipselect && s1_write && s2_chipselect && s2_write
                    && (s1_address == s2_address);
            step(1'b0, 1'b0, '0, '0);
        end
        reset = 1'b0;
        idle(4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("pending_drained_%0d", i), DW'(pend[i].size()), DW'(0));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
